parity_frame_checker: RTL and testbench

Sequential consumer of 3-input XNOR parity checks. Accepts a stream of WIDTH-bit words under a valid/ready handshake and checks each word for even parity (word OK when the XNOR-reduction of its bits is 1, i.e. an even number of ones). Over a frame of FRAME_LEN words it accumulates the bad-word count and the column (bitwise XOR) parity, then presents a frame report on an output handshake. Sits directly downstream of the xnor_gate parity check stage.

---
 rtl/parity_frame_checker.sv | 149 ++++++++++++++
 tb/tb_parity_frame_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// Frame-level even-parity checker: counts odd-parity words and column parity over
// FRAME_LEN accepted words, then presents a report on a valid/ready output.
module parity_frame_checker #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned BAD_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BAD_W-1:0] out_bad_cnt,
  output logic [WIDTH-1:0] out_col_par,
  output logic             out_frame_ok,
  output logic             word_ok,
  output logic [CNT_W-1:0] total_err,
  input  logic             clr_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BAD_W-1:0]   word_cnt_q, word_cnt_d;
  logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
  logic [WIDTH-1:0]   col_q, col_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [BAD_W-1:0]   out_bad_cnt_q, out_bad_cnt_d;
  logic [WIDTH-1:0]   out_col_par_q, out_col_par_d;
  logic               out_frame_ok_q, out_frame_ok_d;
  logic               word_ok_q, word_ok_d;
  logic [CNT_W-1:0]   total_err_q, total_err_d;

  logic               accept;
  logic               bad;
  logic               frame_done;
  logic [BAD_W-1:0]   bad_cnt_next;
  logic [WIDTH-1:0]   col_next;

  // Next-state, accumulator and report logic
  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    bad_cnt_d      = bad_cnt_q;
    col_d          = col_q;
    out_valid_d    = out_valid_q;
    out_bad_cnt_d  = out_bad_cnt_q;
    out_col_par_d  = out_col_par_q;
    out_frame_ok_d = out_frame_ok_q;
    word_ok_d      = word_ok_q;
    total_err_d    = total_err_q;

    accept       = in_valid && in_ready_q;
    bad          = ^in_data;
    frame_done   = (word_cnt_q == BAD_W'(FRAME_LEN - 1));
    bad_cnt_next = bad_cnt_q + BAD_W'(bad);
    col_next     = col_q ^ in_data;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (frame_done) begin
            // Report includes the final word; accumulators restart for the next frame
            state_d        = REPORT;
            out_valid_d    = 1'b1;
            out_bad_cnt_d  = bad_cnt_next;
            out_col_par_d  = col_next;
            out_frame_ok_d = (bad_cnt_next == '0);
            word_cnt_d     = '0;
            bad_cnt_d      = '0;
            col_d          = '0;
          end else begin
            state_d    = ACCUM;
            word_cnt_d = word_cnt_q + BAD_W'(1);
            bad_cnt_d  = bad_cnt_next;
            col_d      = col_next;
          end
        end
      end
      REPORT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      word_ok_d = ~bad;
    end

    // Clear wins over a coincident bad-word increment
    if (clr_err) begin
      total_err_d = '0;
    end else if (accept && bad && (total_err_q != {CNT_W{1'b1}})) begin
      total_err_d = total_err_q + CNT_W'(1);
    end

    in_ready_d = (state_d != REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      word_cnt_q     <= '0;
      bad_cnt_q      <= '0;
      col_q          <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_bad_cnt_q  <= '0;
      out_col_par_q  <= '0;
      out_frame_ok_q <= 1'b0;
      word_ok_q      <= 1'b0;
      total_err_q    <= '0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
      col_q          <= col_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      out_bad_cnt_q  <= out_bad_cnt_d;
      out_col_par_q  <= out_col_par_d;
      out_frame_ok_q <= out_frame_ok_d;
      word_ok_q      <= word_ok_d;
      total_err_q    <= total_err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_bad_cnt  = out_bad_cnt_q;
  assign out_col_par  = out_col_par_q;
  assign out_frame_ok = out_frame_ok_q;
  assign word_ok      = word_ok_q;
  assign total_err    = total_err_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (WIDTH=3, FRAME_LEN=4, CNT_W=2).
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bad_cnt;
  logic [2:0] out_col_par;
  logic       out_frame_ok;
  logic       word_ok;
  logic [1:0] total_err;
  logic       clr_err;

  int checks = 0;
  int errors = 0;

  parity_frame_checker #(
    .WIDTH(3), .FRAME_LEN(4), .CNT_W(2), .BAD_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bad_cnt(out_bad_cnt), .out_col_par(out_col_par), .out_frame_ok(out_frame_ok),
    .word_ok(word_ok), .total_err(total_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [2:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_err = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %0b exp 0", out_valid); end
    checks++; if (out_bad_cnt !== 4'd0) begin errors++; $display("FAIL reset out_bad_cnt got %0d exp 0", out_bad_cnt); end
    checks++; if (out_col_par !== 3'b000) begin errors++; $display("FAIL reset out_col_par got %b exp 000", out_col_par); end
    checks++; if (out_frame_ok !== 1'b0) begin errors++; $display("FAIL reset out_frame_ok got %0b exp 0", out_frame_ok); end
    checks++; if (word_ok !== 1'b0) begin errors++; $display("FAIL reset word_ok got %0b exp 0", word_ok); end
    checks++; if (total_err !== 2'd0) begin errors++; $display("FAIL reset total_err got %0d exp 0", total_err); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_clean_frame();
    logic [2:0] w [4] = '{3'b000, 3'b011, 3'b110, 3'b101};
    for (int i = 0; i < 4; i++) begin
      send_word(w[i]);
      checks++; if (word_ok !== 1'b1) begin errors++; $display("FAIL clean word_ok[%0d] got %0b exp 1", i, word_ok); end
      if (i == 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean early out_valid got %0b exp 0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean out_valid got %0b exp 1", out_valid); end
    checks++; if (out_bad_cnt !== 4'd0) begin errors++; $display("FAIL clean out_bad_cnt got %0d exp 0", out_bad_cnt); end
    checks++; if (out_col_par !== 3'b000) begin errors++; $display("FAIL clean out_col_par got %b exp 000", out_col_par); end
    checks++; if (out_frame_ok !== 1'b1) begin errors++; $display("FAIL clean out_frame_ok got %0b exp 1", out_frame_ok); end
    checks++; if (total_err !== 2'd0) begin errors++; $display("FAIL clean total_err got %0d exp 0", total_err); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clean in_ready in report got %0b exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean out_valid after hs got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clean in_ready after hs got %0b exp 1", in_ready); end
    checks++; if (out_frame_ok !== 1'b1) begin errors++; $display("FAIL clean out_frame_ok hold got %0b exp 1", out_frame_ok); end
  endtask

  task automatic test_bad_frame();
    logic [2:0] w [4]   = '{3'b001, 3'b011, 3'b111, 3'b000};
    logic       exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send_word(w[i]);
      checks++; if (word_ok !== exp[i]) begin errors++; $display("FAIL bad word_ok[%0d] got %0b exp %0b", i, word_ok, exp[i]); end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bad out_valid got %0b exp 1", out_valid); end
    checks++; if (out_bad_cnt !== 4'd2) begin errors++; $display("FAIL bad out_bad_cnt got %0d exp 2", out_bad_cnt); end
    checks++; if (out_col_par !== 3'b101) begin errors++; $display("FAIL bad out_col_par got %b exp 101", out_col_par); end
    checks++; if (out_frame_ok !== 1'b0) begin errors++; $display("FAIL bad out_frame_ok got %0b exp 0", out_frame_ok); end
    checks++; if (total_err !== 2'd2) begin errors++; $display("FAIL bad total_err got %0d exp 2", total_err); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bad out_valid after hs got %0b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [2:0] w [4]  = '{3'b011, 3'b101, 3'b110, 3'b111};
    logic [2:0] jk [5] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
    logic [2:0] w2 [4] = '{3'b000, 3'b000, 3'b000, 3'b011};
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (total_err !== 2'd0) begin errors++; $display("FAIL bp clr total_err got %0d exp 0", total_err); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(w[i]);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = jk[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_bad_cnt !== 4'd1 || out_col_par !== 3'b111 ||
          out_frame_ok !== 1'b0 || in_ready !== 1'b0 || total_err !== 2'd1 || word_ok !== 1'b0) begin
        errors++;
        $display("FAIL bp hold[%0d] got v=%0b bad=%0d col=%b ok=%0b rdy=%0b err=%0d wok=%0b exp v=1 bad=1 col=111 ok=0 rdy=0 err=1 wok=0",
                 i, out_valid, out_bad_cnt, out_col_par, out_frame_ok, in_ready, total_err, word_ok);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp out_valid after hs got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp in_ready after hs got %0b exp 1", in_ready); end
    for (int i = 0; i < 4; i++) send_word(w2[i]);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp next out_valid got %0b exp 1", out_valid); end
    checks++; if (out_bad_cnt !== 4'd0) begin errors++; $display("FAIL bp next out_bad_cnt got %0d exp 0", out_bad_cnt); end
    checks++; if (out_col_par !== 3'b011) begin errors++; $display("FAIL bp next out_col_par got %b exp 011", out_col_par); end
    tick();
  endtask

  task automatic test_valid_gaps();
    logic [2:0] w [4]   = '{3'b001, 3'b011, 3'b111, 3'b000};
    logic       exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       v [9]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = v[i];
      in_data  = v[i] ? w[k] : 3'b111;
      tick();
      if (v[i]) k++;
      in_valid = 1'b0;
      checks++; if (word_ok !== exp[k-1]) begin errors++; $display("FAIL gaps word_ok cyc %0d got %0b exp %0b", i, word_ok, exp[k-1]); end
      if (i == 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps early out_valid got %0b exp 0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gaps out_valid got %0b exp 1", out_valid); end
    checks++; if (out_bad_cnt !== 4'd2) begin errors++; $display("FAIL gaps out_bad_cnt got %0d exp 2", out_bad_cnt); end
    checks++; if (out_col_par !== 3'b101) begin errors++; $display("FAIL gaps out_col_par got %b exp 101", out_col_par); end
    checks++; if (out_frame_ok !== 1'b0) begin errors++; $display("FAIL gaps out_frame_ok got %0b exp 0", out_frame_ok); end
    checks++; if (total_err !== 2'd3) begin errors++; $display("FAIL gaps total_err got %0d exp 3", total_err); end
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] exp [8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (total_err !== 2'd0) begin errors++; $display("FAIL sat clr total_err got %0d exp 0", total_err); end
    for (int i = 0; i < 8; i++) begin
      send_word(3'b111);
      checks++; if (total_err !== exp[i]) begin errors++; $display("FAIL sat total_err[%0d] got %0d exp %0d", i, total_err, exp[i]); end
      if (i % 4 == 3) begin
        checks++;
        if (out_bad_cnt !== 4'd4 || out_col_par !== 3'b000) begin
          errors++;
          $display("FAIL sat report got bad=%0d col=%b exp bad=4 col=000", out_bad_cnt, out_col_par);
        end
        tick();
      end
    end
    clr_err = 1'b1;
    send_word(3'b111);
    clr_err = 1'b0;
    checks++; if (total_err !== 2'd0) begin errors++; $display("FAIL sat clr+bad total_err got %0d exp 0", total_err); end
    checks++; if (word_ok !== 1'b0) begin errors++; $display("FAIL sat clr+bad word_ok got %0b exp 0", word_ok); end
  endtask

  task automatic test_async_reset();
    logic [2:0] w [4] = '{3'b000, 3'b011, 3'b110, 3'b101};
    send_word(3'b011);
    checks++; if (word_ok !== 1'b1) begin errors++; $display("FAIL arst pre word_ok got %0b exp 1", word_ok); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (word_ok !== 1'b0) begin errors++; $display("FAIL arst word_ok got %0b exp 0", word_ok); end
    checks++; if (out_valid !== 1'b0 || total_err !== 2'd0 || out_bad_cnt !== 4'd0) begin
      errors++; $display("FAIL arst outs got v=%0b err=%0d bad=%0d exp all 0", out_valid, total_err, out_bad_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst in_ready got %0b exp 1", in_ready); end
    for (int i = 0; i < 4; i++) send_word(w[i]);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst out_valid got %0b exp 1", out_valid); end
    checks++; if (out_bad_cnt !== 4'd0) begin errors++; $display("FAIL arst out_bad_cnt got %0d exp 0", out_bad_cnt); end
    checks++; if (out_col_par !== 3'b000) begin errors++; $display("FAIL arst out_col_par got %b exp 000", out_col_par); end
    checks++; if (out_frame_ok !== 1'b1) begin errors++; $display("FAIL arst out_frame_ok got %0b exp 1", out_frame_ok); end
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_bad_frame();
    test_backpressure();
    test_valid_gaps();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
